// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for an in-order pipeline: load-use bubble, branch flush, EX forwarding selects.
// Optional PERF_CNT_EN macro adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int STAGES       = 5,
  parameter int REG_ADDR_W   = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int CNT_W        = 32,
  localparam int SEL_W       = $clog2(STAGES)
) (
  input  logic                  clock_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regWrite_i,
  input  logic                  id_memRead_i,
  input  logic                  br_taken_i,
  output logic                  write_PC_o,
  output logic                  write_IFID_o,
  output logic [STAGES-1:0]     flush_mask_o,
  output logic [STAGES-1:0]     stage_valid_o,
  output logic [SEL_W-1:0]      fwdA_o,
  output logic [SEL_W-1:0]      fwdB_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // Stage 1 (ID) fields come straight from the inputs; only EX and older are stored.
  logic [STAGES-1:0]                  valid_q, valid_d, flush;
  logic [STAGES-1:2][REG_ADDR_W-1:0]  rd_q, rd_d;
  logic [STAGES-1:2]                  rw_q, rw_d;
  logic                               mr_q, mr_d;
  logic [REG_ADDR_W-1:0]              rs_q, rs_d, rt_q, rt_d;
  logic                               taken, load_use, stall;

  always_comb begin
    taken    = br_taken_i & valid_q[BRANCH_STAGE];
    load_use = valid_q[1] & valid_q[2] & mr_q & rw_q[2] & (rd_q[2] != '0) &
               ((id_use_rs_i & (rd_q[2] == id_rs_i)) | (id_use_rt_i & (rd_q[2] == id_rt_i)));
    stall    = load_use & ~taken;
    flush    = '0;
    if (taken)      flush[BRANCH_STAGE:0] = '1;
    else if (stall) flush[2] = 1'b1;
  end

  always_comb begin
    valid_d[0]          = stall ? valid_q[0] : in_valid_i;
    valid_d[1]          = stall ? valid_q[1] : valid_q[0];
    valid_d[STAGES-1:2] = valid_q[STAGES-2:1];
    valid_d             = valid_d & ~flush;
    rd_d[2] = id_rd_i;
    rw_d[2] = id_regWrite_i;
    mr_d    = id_memRead_i;
    rs_d    = id_use_rs_i ? id_rs_i : '0;
    rt_d    = id_use_rt_i ? id_rt_i : '0;
    for (int k = 3; k < STAGES; k++) begin
      rd_d[k] = rd_q[k-1];
      rw_d[k] = rw_q[k-1];
    end
    // Bubbles carry no register effects so they can never forward or trigger a stall.
    for (int k = 2; k < STAGES; k++) begin
      if (flush[k]) begin
        rd_d[k] = '0;
        rw_d[k] = 1'b0;
      end
    end
    if (flush[2]) begin
      mr_d = 1'b0;
      rs_d = '0;
      rt_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rd_q    <= '0;
      rw_q    <= '0;
      mr_q    <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end

  // Scan oldest to youngest so the youngest matching producer is the last one assigned.
  always_comb begin
    fwdA_o = '0;
    fwdB_o = '0;
    for (int k = STAGES-1; k >= 3; k--) begin
      if (valid_q[k] & rw_q[k] & (rd_q[k] != '0)) begin
        if (rd_q[k] == rs_q) fwdA_o = SEL_W'(k);
        if (rd_q[k] == rt_q) fwdB_o = SEL_W'(k);
      end
    end
  end

  assign write_PC_o    = ~stall;
  assign write_IFID_o  = ~stall;
  assign stall_o       = stall;
  assign flush_mask_o  = flush;
  assign stage_valid_o = valid_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 5-stage instance and a 7-stage (branch at 3, 2-bit counters) instance.
module tb_pipe_hazard_ctrl;

`ifdef PERF_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // 5-stage instance
  logic        rst, in_valid, use_rs, use_rt, id_rw, id_mr, br;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        wpc, wifid, st;
  logic [4:0]  fm, sv;
  logic [2:0]  fa, fb;
  logic [31:0] scnt, fcnt;

  pipe_hazard_ctrl #(.STAGES(5), .REG_ADDR_W(5), .BRANCH_STAGE(2), .CNT_W(32)) u_a (
    .clock_i(clk), .rst_i(rst), .in_valid_i(in_valid),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(use_rs), .id_use_rt_i(use_rt),
    .id_rd_i(id_rd), .id_regWrite_i(id_rw), .id_memRead_i(id_mr), .br_taken_i(br),
    .write_PC_o(wpc), .write_IFID_o(wifid), .flush_mask_o(fm), .stage_valid_o(sv),
    .fwdA_o(fa), .fwdB_o(fb), .stall_o(st), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  // 7-stage instance
  logic        b_rst, b_in_valid, b_use_rs, b_use_rt, b_id_rw, b_id_mr, b_br;
  logic [4:0]  b_id_rs, b_id_rt, b_id_rd;
  logic        b_wpc, b_wifid, b_st;
  logic [6:0]  b_fm, b_sv;
  logic [2:0]  b_fa, b_fb;
  logic [1:0]  b_scnt, b_fcnt;

  pipe_hazard_ctrl #(.STAGES(7), .REG_ADDR_W(5), .BRANCH_STAGE(3), .CNT_W(2)) u_b (
    .clock_i(clk), .rst_i(b_rst), .in_valid_i(b_in_valid),
    .id_rs_i(b_id_rs), .id_rt_i(b_id_rt), .id_use_rs_i(b_use_rs), .id_use_rt_i(b_use_rt),
    .id_rd_i(b_id_rd), .id_regWrite_i(b_id_rw), .id_memRead_i(b_id_mr), .br_taken_i(b_br),
    .write_PC_o(b_wpc), .write_IFID_o(b_wifid), .flush_mask_o(b_fm), .stage_valid_o(b_sv),
    .fwdA_o(b_fa), .fwdB_o(b_fb), .stall_o(b_st), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_rs = rs; id_rt = rt; use_rs = urs; use_rt = urt; id_rd = rd; id_rw = rw; id_mr = mr;
  endtask

  task automatic set_id_b(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                          input logic [4:0] rd, input logic rw, input logic mr);
    b_id_rs = rs; b_id_rt = rt; b_use_rs = urs; b_use_rt = urt; b_id_rd = rd; b_id_rw = rw; b_id_mr = mr;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; br = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic do_reset_b();
    b_rst = 1'b1; b_in_valid = 1'b1; b_br = 1'b0; set_id_b(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    b_rst = 1'b0; b_in_valid = 1'b0;
  endtask

  // Leaves lw r5 in EX and add r6,r5,r1 in ID, inputs settled.
  task automatic load_use_setup();
    do_reset();
    in_valid = 1'b1; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b0; set_id(0, 0, 0, 0, 5, 1, 1); tick();
    set_id(5, 1, 1, 1, 6, 1, 0); #1;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    tests++; if (sv !== 5'b0) begin failed++; $display("FAIL reset_valid got %b want %b", sv, 5'b0); end
    tests++; if ({wpc, wifid, st} !== 3'b110) begin failed++; $display("FAIL reset_ctrl got %b want 110", {wpc, wifid, st}); end
    tests++; if ({fm, fa, fb} !== 11'b0) begin failed++; $display("FAIL reset_fm_fwd got %b want 0", {fm, fa, fb}); end
    tests++; if ({scnt, fcnt} !== 64'b0) begin failed++; $display("FAIL reset_cnt got %0h/%0h want 0/0", scnt, fcnt); end
  endtask

  task automatic test_load_use();
    load_use_setup();
    tests++; if (st !== 1'b1) begin failed++; $display("FAIL lu_stall got %b want 1", st); end
    tests++; if (fm !== 5'b00100) begin failed++; $display("FAIL lu_flush got %b want 00100", fm); end
    tests++; if ({wpc, wifid} !== 2'b00) begin failed++; $display("FAIL lu_wen got %b want 00", {wpc, wifid}); end
    tests++; if (sv !== 5'b00110) begin failed++; $display("FAIL lu_valid0 got %b want 00110", sv); end
    tick();
    tests++; if ({st, wpc, wifid, fm} !== 8'b0_1_1_00000) begin failed++; $display("FAIL lu_release got %b want 01100000", {st, wpc, wifid, fm}); end
    tests++; if (sv !== 5'b01010) begin failed++; $display("FAIL lu_valid1 got %b want 01010", sv); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if ({fa, fb} !== {3'd4, 3'd0}) begin failed++; $display("FAIL lu_fwd got %0d/%0d want 4/0", fa, fb); end
    tests++; if (sv !== 5'b10100) begin failed++; $display("FAIL lu_valid2 got %b want 10100", sv); end
    tests++; if (scnt !== (CNT_ON ? 32'd1 : 32'd0)) begin failed++; $display("FAIL lu_stall_cnt got %0d want %0d", scnt, CNT_ON ? 1 : 0); end
  endtask

  task automatic test_fwd(input logic [4:0] rd1, input logic [4:0] rd2, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [2:0] exp_a, input logic [2:0] exp_b);
    do_reset();
    in_valid = 1'b1; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b1; set_id(0, 0, 0, 0, rd1, 1, 0); tick();
    in_valid = 1'b0; set_id(0, 0, 0, 0, rd2, 1, 0); tick();
    set_id(rs, rt, 1, 1, 0, 0, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if ({fa, fb} !== {exp_a, exp_b})
      begin failed++; $display("FAIL fwd rd%0d/rd%0d src %0d/%0d got %0d/%0d want %0d/%0d", rd1, rd2, rs, rt, fa, fb, exp_a, exp_b); end
    tests++; if ({sv, st} !== 6'b11100_0) begin failed++; $display("FAIL fwd_valid got %b want 111000", {sv, st}); end
  endtask

  task automatic test_branch();
    do_reset();
    in_valid = 1'b1; tick(); tick(); tick();
    br = 1'b1; #1;
    tests++; if (fm !== 5'b00111) begin failed++; $display("FAIL br_flush got %b want 00111", fm); end
    tests++; if ({st, wpc} !== 2'b01) begin failed++; $display("FAIL br_ctrl got %b want 01", {st, wpc}); end
    tick();
    tests++; if (sv !== 5'b01000) begin failed++; $display("FAIL br_valid got %b want 01000", sv); end
    tests++; if (fm !== 5'b00000) begin failed++; $display("FAIL br_invalid_ignored got %b want 00000", fm); end
    tests++; if (fcnt !== (CNT_ON ? 32'd1 : 32'd0)) begin failed++; $display("FAIL br_flush_cnt got %0d want %0d", fcnt, CNT_ON ? 1 : 0); end
    br = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_simultaneous();
    load_use_setup();
    br = 1'b1; #1;
    tests++; if ({st, wpc, wifid} !== 3'b011) begin failed++; $display("FAIL sim_ctrl got %b want 011", {st, wpc, wifid}); end
    tests++; if (fm !== 5'b00111) begin failed++; $display("FAIL sim_flush got %b want 00111", fm); end
    tick();
    br = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (sv !== 5'b01000) begin failed++; $display("FAIL sim_valid got %b want 01000", sv); end
    tests++; if (scnt !== 32'd0) begin failed++; $display("FAIL sim_stall_cnt got %0d want 0", scnt); end
    tests++; if (fcnt !== (CNT_ON ? 32'd1 : 32'd0)) begin failed++; $display("FAIL sim_flush_cnt got %0d want %0d", fcnt, CNT_ON ? 1 : 0); end
  endtask

  task automatic test_reset_mid_stall();
    load_use_setup();
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    tests++; if ({sv, st, fm, wpc} !== {5'b0, 1'b0, 5'b0, 1'b1}) begin failed++; $display("FAIL rst_mid_stall got %b want 00000000001", {sv, st, fm, wpc}); end
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_deep();
    do_reset_b();
    b_in_valid = 1'b1; tick();
    b_in_valid = 1'b0; tick();
    set_id_b(0, 0, 0, 0, 7, 1, 0); tick();
    set_id_b(0, 0, 0, 0, 0, 0, 0); tick();
    b_in_valid = 1'b1; tick();
    b_in_valid = 1'b0; tick();
    set_id_b(0, 7, 0, 1, 0, 0, 0); tick();
    set_id_b(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if ({b_fa, b_fb} !== {3'd0, 3'd6}) begin failed++; $display("FAIL deep_fwd got %0d/%0d want 0/6", b_fa, b_fb); end
    tests++; if (b_sv !== 7'b1000100) begin failed++; $display("FAIL deep_valid0 got %b want 1000100", b_sv); end
    b_br = 1'b1; #1;
    tests++; if (b_fm !== 7'b0) begin failed++; $display("FAIL deep_br_ignored got %b want 0000000", b_fm); end
    tick();
    b_in_valid = 1'b1; #1;
    tests++; if (b_fm !== 7'b0001111) begin failed++; $display("FAIL deep_flush got %b want 0001111", b_fm); end
    tests++; if (b_sv !== 7'b0001000) begin failed++; $display("FAIL deep_valid1 got %b want 0001000", b_sv); end
    tick();
    b_br = 1'b0; b_in_valid = 1'b0; #1;
    tests++; if (b_sv !== 7'b0010000) begin failed++; $display("FAIL deep_valid2 got %b want 0010000", b_sv); end
  endtask

  // Every ID instruction is "lw r5, (r5)": stalls on alternate cycles, five in twelve cycles.
  task automatic test_stall_sat();
    int nst;
    nst = 0;
    do_reset_b();
    b_in_valid = 1'b1; set_id_b(5, 0, 1, 0, 5, 1, 1); #1;
    for (int i = 0; i < 12; i++) begin
      if (b_st === 1'b1) nst++;
      tick();
    end
    tests++; if (nst !== 5) begin failed++; $display("FAIL sat_stall_cycles got %0d want 5", nst); end
    tests++; if (b_scnt !== (CNT_ON ? 2'd3 : 2'd0)) begin failed++; $display("FAIL sat_stall_cnt got %0d want %0d", b_scnt, CNT_ON ? 3 : 0); end
    b_in_valid = 1'b0; set_id_b(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; br = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0);
    b_rst = 1'b1; b_in_valid = 1'b0; b_br = 1'b0; set_id_b(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_fwd(3, 3, 3, 0, 3'd3, 3'd0);
    test_fwd(3, 0, 3, 3, 3'd4, 3'd4);
    test_fwd(0, 0, 0, 0, 3'd0, 3'd0);
    test_fwd(7, 9, 9, 7, 3'd3, 3'd4);
    test_fwd(4, 5, 6, 6, 3'd0, 3'd0);
    test_branch();
    test_simultaneous();
    test_reset_mid_stall();
    test_deep();
    test_stall_sat();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
